// File: rtl/dsp_file_ctrl_pkg.sv
// Shared definitions for the DSP file controller.
//   - FSM state encoding for the request handshake
//   - operation kinds latched from the request lines
//   - pointer step (bytes per word) and file_num port width
package dsp_file_ctrl_pkg;

  localparam int DSP_FILE_PTR_STEP = 4;
  localparam int DSP_FILE_NUM_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } file_state_t;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_RESET = 2'd2
  } file_op_t;

  // Pointer reset wins over write, write wins over read.
  function automatic file_op_t pick_op(input logic rst_req, input logic wr_req);
    if (rst_req) return OP_RESET;
    if (wr_req)  return OP_WRITE;
    return OP_READ;
  endfunction

endpackage

// File: rtl/dsp_file_ram.sv
// Single-port synchronous RAM holding every file, one word per address.
// Ports:
//   wb_clk  clock
//   we      write enable for addr
//   addr    {file select, word index}
//   wdata   write data
//   rdata   registered read data of addr (one-cycle latency, old data on write)
module dsp_file_ram #(
  parameter int DW = 32,
  parameter int AW = 11
) (
  input  logic          wb_clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge wb_clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dsp_file_ctrl.sv
// Per-file storage and byte-pointer manager for the DSP equation engines.
// One read / write / pointer reset per file_* handshake:
//   IDLE -> ACCESS -> HOLD -> RELEASE -> IDLE, file_active high in ACCESS and HOLD.
// Ports:
//   wb_clk, wb_rst      clock, synchronous active-high reset
//   file_num            file selected (>= NUM_FILES is illegal)
//   file_read/write/reset  level requests, held until file_active is seen
//   file_rd_ptr_offset  byte offset added to rd_ptr for reads
//   file_write_data     write data
//   file_read_data      read data, valid in HOLD, held until the next read
//   file_active         operation in progress
//   rd_ptr, wr_ptr      pointers of the live file_num
//   error               one-cycle pulse in ACCESS on an illegal request
// Optional feature: define DSP_FILE_BOUNDS_CHECK_EN to drop writes to a full
// file and zero reads beyond the written region (both pulse error).
module dsp_file_ctrl
  import dsp_file_ctrl_pkg::*;
#(
  parameter int dw         = 32,
  parameter int NUM_FILES  = 8,
  parameter int FILE_DEPTH = 256
) (
  input  logic                      wb_clk,
  input  logic                      wb_rst,
  input  logic [DSP_FILE_NUM_W-1:0] file_num,
  input  logic                      file_read,
  input  logic                      file_write,
  input  logic                      file_reset,
  input  logic [31:0]               file_rd_ptr_offset,
  input  logic [dw-1:0]             file_write_data,
  output logic [dw-1:0]             file_read_data,
  output logic                      file_active,
  output logic [31:0]               rd_ptr,
  output logic [31:0]               wr_ptr,
  output logic                      error
);

  localparam int WIDX_W = $clog2(FILE_DEPTH);
  localparam int PTR_W  = WIDX_W + 2;
  localparam int FSEL_W = (NUM_FILES > 1) ? $clog2(NUM_FILES) : 1;
  localparam int AW     = FSEL_W + WIDX_W;
  localparam logic [PTR_W-1:0]          STEP    = PTR_W'(DSP_FILE_PTR_STEP);
  localparam logic [DSP_FILE_NUM_W-1:0] NFILE_L = DSP_FILE_NUM_W'(NUM_FILES);

  file_state_t               state_reg, state_next;
  file_op_t                  op_reg;
  logic [DSP_FILE_NUM_W-1:0] file_num_reg;
  logic [31:0]               offset_reg;
  logic [dw-1:0]             wdata_reg;
  logic [dw-1:0]             data_reg;
  logic                      rd_hit_reg, rd_zero_reg;

  logic [PTR_W-1:0] rd_all [NUM_FILES];
  logic [PTR_W-1:0] wr_all [NUM_FILES];

  logic              any_req, legal, live_legal, in_access;
  logic [FSEL_W-1:0] fsel, live_sel;
  logic [PTR_W-1:0]  cur_rd, cur_wr, rd_byte;
  logic [WIDX_W-1:0] rd_widx, wr_widx;
  logic              do_reset, do_write, do_read, rd_step;
  logic              wr_drop, rd_oob;
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [dw-1:0]     ram_rdata;

  assign any_req    = file_read | file_write | file_reset;
  assign legal      = file_num_reg < NFILE_L;
  assign live_legal = file_num < NFILE_L;
  assign fsel       = file_num_reg[FSEL_W-1:0];
  assign live_sel   = file_num[FSEL_W-1:0];
  assign in_access  = (state_reg == ST_ACCESS);

  assign cur_rd  = rd_all[fsel];
  assign cur_wr  = wr_all[fsel];
  // Only the low PTR_W offset bits matter: addresses wrap modulo FILE_DEPTH*4.
  assign rd_byte = cur_rd + offset_reg[PTR_W-1:0];
  assign rd_widx = rd_byte[PTR_W-1:2];
  assign wr_widx = cur_wr[PTR_W-1:2];

`ifdef DSP_FILE_BOUNDS_CHECK_EN
  localparam logic [WIDX_W:0] FULL_CNT = (WIDX_W+1)'(FILE_DEPTH);
  logic [WIDX_W:0] cnt_all [NUM_FILES];
  logic [WIDX_W:0] cur_cnt;
  assign cur_cnt = cnt_all[fsel];
  assign wr_drop = (cur_cnt == FULL_CNT);
  assign rd_oob  = ({1'b0, rd_widx} >= cur_cnt);
`else
  assign wr_drop = 1'b0;
  assign rd_oob  = 1'b0;
`endif

  assign do_reset = in_access && legal && (op_reg == OP_RESET);
  assign do_write = in_access && legal && (op_reg == OP_WRITE) && !wr_drop;
  assign do_read  = in_access && legal && (op_reg == OP_READ);
  // Offset reads are random access and leave the stream pointer alone.
  assign rd_step  = do_read && !rd_oob && (offset_reg == '0);

  // A reset arriving in ACCESS must not let the pending write land.
  assign ram_we   = do_write && !wb_rst;
  assign ram_addr = {fsel, (op_reg == OP_WRITE) ? wr_widx : rd_widx};

  dsp_file_ram #(.DW(dw), .AW(AW)) u_ram (
    .wb_clk (wb_clk),
    .we     (ram_we),
    .addr   (ram_addr),
    .wdata  (wdata_reg),
    .rdata  (ram_rdata)
  );

  generate
    for (genvar gi = 0; gi < NUM_FILES; gi++) begin : g_file
      logic [PTR_W-1:0] rd_q, wr_q;
      logic             sel;
      assign sel = (fsel == FSEL_W'(gi));

      always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
          rd_q <= '0;
          wr_q <= '0;
        end else if (sel) begin
          if (do_reset) begin
            rd_q <= '0;
            wr_q <= '0;
          end else begin
            if (do_write) wr_q <= wr_q + STEP;
            if (rd_step)  rd_q <= rd_q + STEP;
          end
        end
      end

      assign rd_all[gi] = rd_q;
      assign wr_all[gi] = wr_q;

`ifdef DSP_FILE_BOUNDS_CHECK_EN
      logic [WIDX_W:0] cnt_q;
      always_ff @(posedge wb_clk) begin
        if (wb_rst || (sel && do_reset)) cnt_q <= '0;
        else if (sel && do_write)        cnt_q <= cnt_q + 1'b1;
      end
      assign cnt_all[gi] = cnt_q;
`endif
    end
  endgenerate

  always_ff @(posedge wb_clk) begin
    if (wb_rst) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    file_active = 1'b0;
    error       = 1'b0;
    case (state_reg)
      ST_IDLE:    if (any_req) state_next = ST_ACCESS;
      ST_ACCESS: begin
        file_active = 1'b1;
        error       = !legal ||
                      (legal && (op_reg == OP_WRITE) && wr_drop) ||
                      (legal && (op_reg == OP_READ)  && rd_oob);
        state_next  = ST_HOLD;
      end
      ST_HOLD: begin
        file_active = 1'b1;
        state_next  = ST_RELEASE;
      end
      ST_RELEASE: if (!any_req) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      op_reg       <= OP_READ;
      file_num_reg <= '0;
      offset_reg   <= '0;
      wdata_reg    <= '0;
      data_reg     <= '0;
      rd_hit_reg   <= 1'b0;
      rd_zero_reg  <= 1'b0;
    end else begin
      if (state_reg == ST_IDLE && any_req) begin
        op_reg       <= pick_op(file_reset, file_write);
        file_num_reg <= file_num;
        offset_reg   <= file_rd_ptr_offset;
        wdata_reg    <= file_write_data;
      end
      rd_hit_reg  <= do_read;
      rd_zero_reg <= rd_oob;
      if (state_reg == ST_HOLD && rd_hit_reg) data_reg <= file_read_data;
    end
  end

  // In HOLD the fresh RAM word is shown directly; afterwards the captured copy.
  assign file_read_data = (state_reg == ST_HOLD && rd_hit_reg) ?
                          (rd_zero_reg ? '0 : ram_rdata) : data_reg;

  assign rd_ptr = live_legal ? 32'(rd_all[live_sel]) : 32'd0;
  assign wr_ptr = live_legal ? 32'(wr_all[live_sel]) : 32'd0;

endmodule

// File: tb/tb_dsp_file_ctrl.sv
module tb_dsp_file_ctrl;

  localparam int K_RD = 0, K_WR = 1, K_RST = 2, K_RW = 3;
  localparam int NF = 8, DEPTH = 256, PMOD = DEPTH * 4;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [7:0]  file_num;
  logic        file_read, file_write, file_reset;
  logic [31:0] file_rd_ptr_offset, file_write_data;
  logic [31:0] file_read_data, rd_ptr, wr_ptr;
  logic        file_active, error;

  dsp_file_ctrl dut (
    .wb_clk             (wb_clk),
    .wb_rst             (wb_rst),
    .file_num           (file_num),
    .file_read          (file_read),
    .file_write         (file_write),
    .file_reset         (file_reset),
    .file_rd_ptr_offset (file_rd_ptr_offset),
    .file_write_data    (file_write_data),
    .file_read_data     (file_read_data),
    .file_active        (file_active),
    .rd_ptr             (rd_ptr),
    .wr_ptr             (wr_ptr),
    .error              (error)
  );

  always #5 wb_clk = ~wb_clk;

  // Behavioural model: file contents, pointer pairs and expected outputs.
  int unsigned mem_m [NF][DEPTH];
  int unsigned exp_rd [NF];
  int unsigned exp_wr [NF];
  int unsigned exp_data;
  logic        exp_active, exp_err;
  logic        chk_en = 1'b0;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic int unsigned view(input int unsigned arr [NF], input logic [7:0] fn);
    return (fn < NF) ? arr[fn] : 0;
  endfunction

  always @(negedge wb_clk) begin
    if (chk_en) begin
      check("file_active", {31'd0, file_active}, {31'd0, exp_active});
      check("error", {31'd0, error}, {31'd0, exp_err});
      check("rd_ptr", rd_ptr, view(exp_rd, file_num));
      check("wr_ptr", wr_ptr, view(exp_wr, file_num));
      check("file_read_data", file_read_data, exp_data);
    end
  end

  // One full handshake; the model moves with the protocol timeline.
  task automatic op(input int kind, input int fn, input logic [31:0] off, input logic [31:0] wd);
    int unsigned a;
    bit legal;
    legal = (fn < NF);
    file_num           = 8'(fn);
    file_rd_ptr_offset = off;
    file_write_data    = wd;
    file_read  = (kind == K_RD)  || (kind == K_RW);
    file_write = (kind == K_WR)  || (kind == K_RW);
    file_reset = (kind == K_RST);
    @(posedge wb_clk); #1;                      // ACCESS
    exp_active = 1'b1;
    exp_err    = !legal;
    file_read = 1'b0; file_write = 1'b0; file_reset = 1'b0;
    @(posedge wb_clk); #1;                      // HOLD
    exp_err = 1'b0;
    if (legal) begin
      if (kind == K_RST) begin
        exp_rd[fn] = 0;
        exp_wr[fn] = 0;
      end else if (kind == K_WR || kind == K_RW) begin
        mem_m[fn][exp_wr[fn] / 4] = wd;
        exp_wr[fn] = (exp_wr[fn] + 4) % PMOD;
      end else begin
        a = ((exp_rd[fn] + off) % PMOD) / 4;
        exp_data = mem_m[fn][a];
        if (off == 0) exp_rd[fn] = (exp_rd[fn] + 4) % PMOD;
      end
    end
    @(posedge wb_clk); #1;                      // RELEASE
    exp_active = 1'b0;
    @(posedge wb_clk); #1;                      // IDLE again
    $display("op kind=%0d file=%0d off=%0d wd=%h -> rd_ptr=%0d wr_ptr=%0d data=%h",
             kind, fn, off, wd, rd_ptr, wr_ptr, file_read_data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    wb_rst = 1'b1;
    file_num = '0; file_read = 0; file_write = 0; file_reset = 0;
    file_rd_ptr_offset = '0; file_write_data = '0;
    exp_data = 0; exp_active = 0; exp_err = 0;
    for (int f = 0; f < NF; f++) begin
      exp_rd[f] = 0;
      exp_wr[f] = 0;
      for (int w = 0; w < DEPTH; w++) mem_m[f][w] = 0;
    end
    repeat (3) @(posedge wb_clk);
    #1 wb_rst = 1'b0;
    chk_en = 1'b1;
    check("reset_active", {31'd0, file_active}, 32'd0);
    check("reset_rd_ptr", rd_ptr, 32'd0);
    check("reset_data", file_read_data, 32'd0);

    // Streaming writes to file 2.
    op(K_WR, 2, 0, 32'hA); check("wr_ptr_4", wr_ptr, 32'd4);
    op(K_WR, 2, 0, 32'hB); check("wr_ptr_8", wr_ptr, 32'd8);
    op(K_WR, 2, 0, 32'hC); check("wr_ptr_12", wr_ptr, 32'd12);

    // Streaming reads back.
    op(K_RD, 2, 0, 0); check("rd_data_A", file_read_data, 32'hA); check("rd_ptr_4", rd_ptr, 32'd4);
    op(K_RD, 2, 0, 0); check("rd_data_B", file_read_data, 32'hB);
    op(K_RD, 2, 0, 0); check("rd_data_C", file_read_data, 32'hC); check("rd_ptr_12", rd_ptr, 32'd12);

    // Pointer reset, then an offset read of stale contents.
    op(K_RST, 2, 0, 0); check("rst_wr_ptr", wr_ptr, 32'd0);
    op(K_RD, 2, 8, 0);  check("off_rd_data", file_read_data, 32'hC); check("off_rd_ptr", rd_ptr, 32'd0);

    // Write beats read.
    op(K_RW, 1, 0, 32'h1234); check("prio_wr_ptr", wr_ptr, 32'd4); check("prio_rd_ptr", rd_ptr, 32'd0);

    // Illegal file number.
    op(K_RD, 9, 0, 0); check("illegal_data_kept", file_read_data, 32'hC);
    file_num = 8'd1; #1 check("illegal_no_change", wr_ptr, 32'd4);

    // Fill file 5 completely; wr_ptr wraps to 0.
    for (int i = 0; i < DEPTH; i++) op(K_WR, 5, 0, 32'(i * 3 + 1));
    check("wrap_wr_ptr", wr_ptr, 32'd0);
    op(K_RD, 5, 1020, 0); check("last_word", file_read_data, 32'h2FE); check("last_rd_ptr", rd_ptr, 32'd0);
    op(K_WR, 5, 0, 32'h77);
    op(K_RD, 5, 0, 0); check("wrapped_word", file_read_data, 32'h77); check("wrap_rd_ptr", rd_ptr, 32'd4);

    // Reset mid-write must abort and leave the RAM word untouched.
    op(K_WR, 3, 0, 32'h11);
    op(K_RST, 3, 0, 0);
    file_num = 8'd3; file_write_data = 32'h99; file_write = 1'b1;
    @(posedge wb_clk); #1;                      // ACCESS of the write
    exp_active = 1'b1;
    file_write = 1'b0;
    wb_rst = 1'b1;
    @(posedge wb_clk); #1;                      // reset taken
    exp_active = 1'b0;
    exp_data   = 0;
    for (int f = 0; f < NF; f++) begin
      exp_rd[f] = 0;
      exp_wr[f] = 0;
    end
    check("abort_active", {31'd0, file_active}, 32'd0);
    check("abort_wr_ptr", wr_ptr, 32'd0);
    wb_rst = 1'b0;
    @(posedge wb_clk); #1;
    $display("abort write file=3 -> active=%0d wr_ptr=%0d", file_active, wr_ptr);
    op(K_RD, 3, 0, 0); check("abort_ram_kept", file_read_data, 32'h11);
    file_num = 8'd5; #1 check("abort_all_ptrs", wr_ptr, 32'd0);

    @(negedge wb_clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
